// File: rtl/fir8_stream_adapter_pkg.sv
// rtl/fir8_stream_adapter_pkg.sv - shared widths, FSM encoding and beat selection for the FIR8 adapter
package fir8_stream_adapter_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } fsm_state_t;

    function automatic logic [BYTE_W-1:0] beat_byte(
        input logic [WORD_W-1:0] word,
        input logic              second,
        input logic              msb_first
    );
        return (second ^ msb_first) ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/fir8_stream_adapter_sync_fifo.sv
// rtl/fir8_stream_adapter_sync_fifo.sv - synchronous FIFO with registered full/empty and fill count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic             r_full, r_empty, w_wr, w_rd;

    // A push while full is only taken when a pop frees the slot in the same cycle
    assign w_wr        = i_push & (~r_full | i_pop);
    assign w_rd        = i_pop & ~r_empty;
    assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/fir8_stream_adapter.sv
// rtl/fir8_stream_adapter.sv - byte stream to FIR8 ap_ctrl_hs bridge with sample and result buffering
module fir8_stream_adapter
    import fir8_stream_adapter_pkg::*;
#(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 1024,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              fir_ap_start,
    output logic [BYTE_W-1:0] fir_x,
    input  logic              fir_ap_done,
    input  logic              fir_ap_idle,
    input  logic              fir_ap_ready,
    input  logic              fir_y_ap_vld,
    input  logic [WORD_W-1:0] fir_y,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_ovf
);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

    fsm_state_t        r_state, w_state_nxt;
    logic [TW-1:0]     r_tmo;
    logic [BYTE_W-1:0] r_x;
    logic [WORD_W-1:0] r_hold;
    logic              r_hold_vld, r_beat, r_rdy_en, r_err_tmo, r_err_ovf;

    logic              w_in_push, w_in_pop, w_in_full, w_in_empty;
    logic [BYTE_W-1:0] w_in_data;
    logic [IN_CW-1:0]  w_in_count;
    logic              w_out_push, w_out_full, w_out_empty, w_ser_load;
    logic [WORD_W-1:0] w_out_data;
    logic [OUT_CW-1:0] w_out_count;
    logic              w_abort, w_tmo_hit;

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .i_clk   (ap_clk),
        .i_rst   (ap_rst),
        .i_push  (w_in_push),
        .i_data  (din),
        .i_pop   (w_in_pop),
        .o_data  (w_in_data),
        .o_full  (w_in_full),
        .o_empty (w_in_empty),
        .o_count (w_in_count)
    );

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .i_clk   (ap_clk),
        .i_rst   (ap_rst),
        .i_push  (w_out_push),
        .i_data  (fir_y),
        .i_pop   (w_ser_load),
        .o_data  (w_out_data),
        .o_full  (w_out_full),
        .o_empty (w_out_empty),
        .o_count (w_out_count)
    );

    // r_rdy_en keeps din_rdy low while reset is held even though the FIFO reads as not full
    assign din_rdy    = r_rdy_en & ~w_in_full;
    assign w_in_push  = din_vld & din_rdy;
    assign w_out_push = fir_y_ap_vld & ~w_out_full;
    assign w_ser_load = ~w_out_empty & (~r_hold_vld | (dout_rdy & r_beat));
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_in_pop    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Requiring a free result slot keeps the single in-flight call from overflowing
                if (!w_in_empty && !w_out_full && fir_ap_idle) begin
                    w_in_pop    = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (fir_ap_ready) begin
                    w_state_nxt = fir_ap_done ? ST_IDLE : ST_WAIT;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (fir_ap_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state   <= ST_IDLE;
            r_tmo     <= '0;
            r_x       <= '0;
            r_rdy_en  <= 1'b0;
            r_err_tmo <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
            r_tmo    <= (r_state == ST_IDLE || w_state_nxt == ST_IDLE) ? '0 : r_tmo + TW'(1);
            if (w_in_pop) r_x <= w_in_data;
            if (w_abort) r_err_tmo <= 1'b1;
            if (fir_y_ap_vld && w_out_full) r_err_ovf <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_beat     <= 1'b0;
        end else if (w_ser_load) begin
            r_hold     <= w_out_data;
            r_hold_vld <= 1'b1;
            r_beat     <= 1'b0;
        end else if (r_hold_vld && dout_rdy) begin
            if (r_beat) r_hold_vld <= 1'b0;
            else        r_beat     <= 1'b1;
        end
    end

    assign fir_ap_start = (r_state == ST_START);
    assign fir_x        = r_x;
    assign dout         = beat_byte(r_hold, r_beat, MSB_FIRST);
    assign dout_vld     = r_hold_vld;
    assign busy         = (r_state != ST_IDLE) | (w_in_count != '0) | (w_out_count != '0) | r_hold_vld;
    assign err_timeout  = r_err_tmo;
    assign err_ovf      = r_err_ovf;

endmodule

// File: tb/tb_fir8_stream_adapter.sv
// tb/tb_fir8_stream_adapter.sv - self-checking bench for fir8_stream_adapter with a FIR8 stub
module tb_fir8_stream_adapter;
    localparam int TIMEOUT   = 1024;
    localparam bit MSB_FIRST = 1'b1;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic [7:0]  din = '0;
    logic        din_vld = 1'b0;
    logic        din_rdy;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_rdy = 1'b1;
    logic        fir_ap_start;
    logic [7:0]  fir_x;
    logic        fir_ap_done, fir_ap_idle, fir_ap_ready, fir_y_ap_vld;
    logic [15:0] fir_y;
    logic        busy, err_timeout, err_ovf;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx[$];
    logic [7:0] exp_q[$];

    int   cfg_ready_dly = 1;
    bit   cfg_hang = 1'b0;
    logic inj_yv = 1'b0;
    logic [15:0] inj_y = '0;

    int          s_phase, s_cnt;
    logic [7:0]  s_x;
    logic        st_ready, st_done, st_yv;
    logic [15:0] st_y;

    int   stall_bad, start_rises, yv_pulses;
    bit   saw_not_rdy, prev_stall, prev_start;
    logic [7:0] prev_dout;

    always #5 ap_clk = ~ap_clk;

    fir8_stream_adapter #(
        .IN_DEPTH(4), .OUT_DEPTH(4), .TIMEOUT(TIMEOUT), .MSB_FIRST(MSB_FIRST)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .fir_ap_start(fir_ap_start), .fir_x(fir_x),
        .fir_ap_done(fir_ap_done), .fir_ap_idle(fir_ap_idle), .fir_ap_ready(fir_ap_ready),
        .fir_y_ap_vld(fir_y_ap_vld), .fir_y(fir_y),
        .busy(busy), .err_timeout(err_timeout), .err_ovf(err_ovf)
    );

    // FIR8 stub: ready cfg_ready_dly cycles after start, done + y = 3*x three cycles after ready
    assign fir_ap_ready = st_ready;
    assign fir_ap_done  = st_done;
    assign fir_ap_idle  = (s_phase == 0);
    assign fir_y_ap_vld = st_yv | inj_yv;
    assign fir_y        = inj_yv ? inj_y : st_y;

    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s_phase <= 0; s_cnt <= 0; s_x <= '0;
            st_ready <= 1'b0; st_done <= 1'b0; st_yv <= 1'b0; st_y <= '0;
        end else begin
            case (s_phase)
                0: if (fir_ap_start) begin
                    s_x <= fir_x;
                    if (cfg_ready_dly <= 1) begin st_ready <= 1'b1; s_phase <= 2; end
                    else begin s_cnt <= 1; s_phase <= 1; end
                end
                1: if (s_cnt + 1 >= cfg_ready_dly) begin st_ready <= 1'b1; s_phase <= 2; end
                   else s_cnt <= s_cnt + 1;
                2: begin
                    st_ready <= 1'b0;
                    if (cfg_hang) s_phase <= 0;
                    else begin s_cnt <= 1; s_phase <= 3; end
                end
                3: if (s_cnt + 1 >= 3) begin
                    st_done <= 1'b1; st_yv <= 1'b1; st_y <= 16'(3 * int'(s_x)); s_phase <= 4;
                end else s_cnt <= s_cnt + 1;
                default: begin st_done <= 1'b0; st_yv <= 1'b0; s_phase <= 0; end
            endcase
        end
    end

    always @(posedge ap_clk) begin
        if (ap_rst) begin
            prev_stall = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (dout_vld && dout_rdy) rx.push_back(dout);
            if (prev_stall && (!dout_vld || dout !== prev_dout)) stall_bad++;
            prev_stall = dout_vld && !dout_rdy;
            prev_dout  = dout;
            if (fir_ap_start && !prev_start) start_rises++;
            prev_start = fir_ap_start;
            if (fir_y_ap_vld) yv_pulses++;
            if (!din_rdy) saw_not_rdy = 1'b1;
        end
    end

    function automatic void expect_sample(input logic [7:0] x);
        logic [15:0] y;
        y = 16'(3 * int'(x));
        if (MSB_FIRST) begin exp_q.push_back(y[15:8]); exp_q.push_back(y[7:0]); end
        else begin exp_q.push_back(y[7:0]); exp_q.push_back(y[15:8]); end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        din = b;
        din_vld = 1'b1;
        while (!din_rdy && n < 300) begin @(negedge ap_clk); n++; end
        if (!din_rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%h din_rdy stayed 0", b);
        end
        @(negedge ap_clk);
        din_vld = 1'b0;
    endtask

    task automatic wait_rx(input int n, output bit ok);
        int c;
        c = 0;
        while (rx.size() < n && c < 4000) begin @(negedge ap_clk); c++; end
        ok = (rx.size() >= n);
    endtask

    task automatic wait_start(output bit ok);
        int c;
        c = 0;
        while (!fir_ap_start && c < 200) begin @(negedge ap_clk); c++; end
        ok = fir_ap_start;
    endtask

    task automatic test_reset;
        logic [20:0] v;
        ap_rst = 1'b0;
        #2 ap_rst = 1'b1;
        repeat (2) @(negedge ap_clk);
        v = {din_rdy, dout, dout_vld, fir_ap_start, fir_x, busy, err_timeout, err_ovf};
        checks++;
        if (v !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", v); end
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++;
        if ({din_rdy, busy} !== 2'b10) begin
            errors++; $display("FAIL reset_release din_rdy,busy got=%b exp=10", {din_rdy, busy});
        end
    endtask

    task automatic test_single;
        bit ok;
        int bad, c;
        rx.delete(); exp_q.delete();
        dout_rdy = 1'b1;
        send_byte(8'h05);
        checks++;
        if (fir_ap_start !== 1'b0) begin errors++; $display("FAIL t1_start_early got=%b exp=0", fir_ap_start); end
        wait_start(ok);
        checks++;
        if (!ok || fir_x !== 8'h05) begin errors++; $display("FAIL t1_fir_x got=%h exp=05 start=%b", fir_x, ok); end
        bad = 0; c = 0;
        while (!fir_ap_ready && c < 50) begin
            if (!fir_ap_start || fir_x !== 8'h05) bad++;
            @(negedge ap_clk); c++;
        end
        @(negedge ap_clk);
        checks++;
        if (bad != 0 || fir_ap_start !== 1'b0) begin
            errors++; $display("FAIL t1_start_hold bad=%0d start_after_ready=%b exp 0/0", bad, fir_ap_start);
        end
        c = 0;
        while (!fir_y_ap_vld && c < 50) begin @(negedge ap_clk); c++; end
        @(negedge ap_clk);
        checks++;
        if (dout_vld !== 1'b0) begin errors++; $display("FAIL t1_dout_early got=%b exp=0", dout_vld); end
        expect_sample(8'h05);
        wait_rx(2, ok);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp_q[i]) begin
                errors++; $display("FAIL t1_beat%0d got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'h00, exp_q[i]);
            end
        end
    endtask

    task automatic test_burst;
        bit ok;
        rx.delete(); exp_q.delete();
        dout_rdy = 1'b0;
        saw_not_rdy = 1'b0;
        stall_bad = 0;
        for (int i = 1; i <= 10; i++) expect_sample(8'(i));
        fork
            for (int i = 1; i <= 10; i++) send_byte(8'(i));
            begin repeat (40) @(negedge ap_clk); dout_rdy = 1'b1; end
        join
        wait_rx(20, ok);
        repeat (5) @(negedge ap_clk);
        checks++;
        if (saw_not_rdy !== 1'b1) begin errors++; $display("FAIL t2_din_rdy_low got=%b exp=1", saw_not_rdy); end
        checks++;
        if (rx.size() != 20) begin errors++; $display("FAIL t2_beat_count got=%0d exp=20", rx.size()); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp_q[i]) begin
                errors++; $display("FAIL t2_beat%0d got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'h00, exp_q[i]);
            end
        end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL t2_dout_stable violations=%0d exp=0", stall_bad); end
    endtask

    task automatic test_ready_delay;
        bit ok;
        int n, bad;
        logic [7:0] x;
        rx.delete(); exp_q.delete();
        x = 8'($urandom);
        cfg_ready_dly = 5;
        start_rises = 0;
        expect_sample(x);
        send_byte(x);
        wait_start(ok);
        n = 0; bad = 0;
        while (fir_ap_start && n < 20) begin
            if (fir_x !== x) bad++;
            @(negedge ap_clk); n++;
        end
        checks++;
        if (n != 6 || bad != 0) begin errors++; $display("FAIL t3_start_window cycles=%0d unstable=%0d exp 6/0", n, bad); end
        wait_rx(2, ok);
        repeat (10) @(negedge ap_clk);
        checks++;
        if (start_rises != 1) begin errors++; $display("FAIL t3_start_count got=%0d exp=1", start_rises); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp_q[i]) begin
                errors++; $display("FAIL t3_beat%0d got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'h00, exp_q[i]);
            end
        end
        cfg_ready_dly = 1;
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        rx.delete(); exp_q.delete();
        cfg_hang = 1'b1;
        send_byte(8'($urandom));
        wait_start(ok);
        n = 0;
        while (!err_timeout && n < TIMEOUT + 50) begin @(negedge ap_clk); n++; end
        checks++;
        if (n != TIMEOUT) begin errors++; $display("FAIL t4_timeout_cycles got=%0d exp=%0d", n, TIMEOUT); end
        checks++;
        if (fir_ap_start !== 1'b0) begin errors++; $display("FAIL t4_start_dropped got=%b exp=0", fir_ap_start); end
        cfg_hang = 1'b0;
        expect_sample(8'h02);
        send_byte(8'h02);
        wait_rx(2, ok);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp_q[i]) begin
                errors++; $display("FAIL t4_beat%0d got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'h00, exp_q[i]);
            end
        end
        checks++;
        if (err_timeout !== 1'b1) begin errors++; $display("FAIL t4_sticky got=%b exp=1", err_timeout); end
    endtask

    task automatic test_overflow;
        bit ok;
        logic [7:0] x;
        rx.delete(); exp_q.delete();
        dout_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom);
            expect_sample(x);
            send_byte(x);
        end
        repeat (80) @(negedge ap_clk);
        checks++;
        if ({err_ovf, busy} !== 2'b01) begin
            errors++; $display("FAIL t5_pre_inject err_ovf,busy got=%b exp=01", {err_ovf, busy});
        end
        inj_y = 16'($urandom);
        inj_yv = 1'b1;
        @(negedge ap_clk);
        inj_yv = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (err_ovf !== 1'b1) begin errors++; $display("FAIL t5_err_ovf got=%b exp=1", err_ovf); end
        dout_rdy = 1'b1;
        wait_rx(12, ok);
        repeat (10) @(negedge ap_clk);
        checks++;
        if (rx.size() != 12) begin errors++; $display("FAIL t5_beat_count got=%0d exp=12", rx.size()); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp_q[i]) begin
                errors++; $display("FAIL t5_beat%0d got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'h00, exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int c;
        logic [20:0] v;
        dout_rdy = 1'b0;
        yv_pulses = 0;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        c = 0;
        while (!(yv_pulses >= 2 && s_phase == 3) && c < 300) begin @(negedge ap_clk); c++; end
        checks++;
        if (!(yv_pulses >= 2 && s_phase == 3) || busy !== 1'b1 || err_timeout !== 1'b1) begin
            errors++; $display("FAIL t6_setup pulses=%0d phase=%0d busy=%b err_timeout=%b", yv_pulses, s_phase, busy, err_timeout);
        end
        ap_rst = 1'b1;
        #1;
        v = {din_rdy, dout, dout_vld, fir_ap_start, fir_x, busy, err_timeout, err_ovf};
        checks++;
        if (v !== '0) begin errors++; $display("FAIL t6_async_reset got=%h exp=0", v); end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        dout_rdy = 1'b1;
        @(negedge ap_clk);
        rx.delete(); exp_q.delete();
        expect_sample(8'h07);
        send_byte(8'h07);
        wait_rx(2, ok);
        repeat (10) @(negedge ap_clk);
        checks++;
        if (rx.size() != 2) begin errors++; $display("FAIL t6_beat_count got=%0d exp=2", rx.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp_q[i]) begin
                errors++; $display("FAIL t6_beat%0d got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'h00, exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        bit ok, done;
        logic [7:0] x;
        rx.delete(); exp_q.delete();
        stall_bad = 0;
        done = 1'b0;
        cfg_ready_dly = $urandom_range(1, 3);
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    x = 8'($urandom);
                    expect_sample(x);
                    send_byte(x);
                    repeat ($urandom_range(0, 3)) @(negedge ap_clk);
                end
                wait_rx(48, ok);
                done = 1'b1;
            end
            while (!done) begin
                @(negedge ap_clk);
                dout_rdy = 1'($urandom_range(0, 1));
            end
        join
        dout_rdy = 1'b1;
        repeat (10) @(negedge ap_clk);
        checks++;
        if (rx.size() != 48) begin errors++; $display("FAIL rnd_beat_count got=%0d exp=48", rx.size()); end
        for (int i = 0; i < 48; i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp_q[i]) begin
                errors++; $display("FAIL rnd_beat%0d got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'h00, exp_q[i]);
            end
        end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL rnd_dout_stable violations=%0d exp=0", stall_bad); end
        cfg_ready_dly = 1;
    endtask

    initial begin
        stall_bad = 0; start_rises = 0; yv_pulses = 0;
        saw_not_rdy = 1'b0; prev_stall = 1'b0; prev_start = 1'b0; prev_dout = '0;
        test_reset();
        test_single();
        test_burst();
        test_ready_delay();
        test_random();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
